// File: rtl/sync_bank_filt.sv
`default_nettype none
// ============================================================================
// sync_bank_filt : multi-channel N-flop level synchronizer with optional
//                  debounce filter and registered rise/fall/change/glitch pulses.
// Revision       : 1.0
// ============================================================================
module sync_bank_filt #(
    parameter int                      NUM_CHANNELS  = 4,
    parameter int                      NUM_STAGES    = 2,
    parameter int                      FILTER_CYCLES = 0,
    parameter logic [NUM_CHANNELS-1:0] RST_VAL       = {NUM_CHANNELS{1'b0}}
) (
    input  logic                    CLK_Dst,
    input  logic                    RST_S,
    input  logic [NUM_CHANNELS-1:0] ASYNC_S,
    output logic [NUM_CHANNELS-1:0] SYNC_S,
    output logic [NUM_CHANNELS-1:0] RISE_P,
    output logic [NUM_CHANNELS-1:0] FALL_P,
    output logic [NUM_CHANNELS-1:0] CHG_P,
    output logic [NUM_CHANNELS-1:0] GLITCH_P
);

    localparam int               CNT_W   = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

    // chain[0] is the metastability-exposed capture flop; chain[NUM_STAGES-1] is safe to use.
    logic [NUM_STAGES-1:0][NUM_CHANNELS-1:0] chain;
    logic [NUM_CHANNELS-1:0]                 last;

    always_ff @(posedge CLK_Dst or negedge RST_S) begin
        if (!RST_S) begin
            chain <= {NUM_STAGES{RST_VAL}};
        end else begin
            chain <= {chain[NUM_STAGES-2:0], ASYNC_S};
        end
    end

    assign last = chain[NUM_STAGES-1];

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             sync_q;
        logic             sync_nxt;
        logic             rise_q;
        logic             rise_nxt;
        logic             fall_q;
        logic             fall_nxt;
        logic             chg_q;
        logic             glitch_q;
        logic             glitch_nxt;

        always_comb begin
            cnt_nxt    = cnt;
            sync_nxt   = sync_q;
            rise_nxt   = 1'b0;
            fall_nxt   = 1'b0;
            glitch_nxt = 1'b0;
            if (last[i] == sync_q) begin
                // A non-zero count here means a pending change was abandoned.
                cnt_nxt    = '0;
                glitch_nxt = (FILTER_CYCLES != 0) && (cnt != '0);
            end else if (cnt == CNT_MAX) begin
                cnt_nxt  = '0;
                sync_nxt = last[i];
                rise_nxt = last[i];
                fall_nxt = ~last[i];
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end

        always_ff @(posedge CLK_Dst or negedge RST_S) begin
            if (!RST_S) begin
                cnt      <= '0;
                sync_q   <= RST_VAL[i];
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                chg_q    <= 1'b0;
                glitch_q <= 1'b0;
            end else begin
                cnt      <= cnt_nxt;
                sync_q   <= sync_nxt;
                rise_q   <= rise_nxt;
                fall_q   <= fall_nxt;
                chg_q    <= rise_nxt | fall_nxt;
                glitch_q <= glitch_nxt;
            end
        end

        assign SYNC_S[i]   = sync_q;
        assign RISE_P[i]   = rise_q;
        assign FALL_P[i]   = fall_q;
        assign CHG_P[i]    = chg_q;
        assign GLITCH_P[i] = glitch_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_bank_filt.sv
`default_nettype none
// ============================================================================
// tb_sync_bank_filt : self-checking bench for sync_bank_filt (three configs).
// Revision          : 1.0
// ============================================================================
module tb_sync_bank_filt;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] async_in = 4'b1010;
    logic       c_in = 1'b0;

    logic [3:0] a_sync, a_rise, a_fall, a_chg, a_glitch;
    logic [3:0] b_sync, b_rise, b_fall, b_chg, b_glitch;
    logic [0:0] c_sync, c_rise, c_fall, c_chg, c_glitch;

    always #5 clk = ~clk;

    sync_bank_filt #(.NUM_CHANNELS(4), .NUM_STAGES(2), .FILTER_CYCLES(0), .RST_VAL(4'b1010)) dut_a (
        .CLK_Dst(clk), .RST_S(rst_n), .ASYNC_S(async_in), .SYNC_S(a_sync),
        .RISE_P(a_rise), .FALL_P(a_fall), .CHG_P(a_chg), .GLITCH_P(a_glitch));

    sync_bank_filt #(.NUM_CHANNELS(4), .NUM_STAGES(2), .FILTER_CYCLES(3), .RST_VAL(4'b0000)) dut_b (
        .CLK_Dst(clk), .RST_S(rst_n), .ASYNC_S(async_in), .SYNC_S(b_sync),
        .RISE_P(b_rise), .FALL_P(b_fall), .CHG_P(b_chg), .GLITCH_P(b_glitch));

    sync_bank_filt #(.NUM_CHANNELS(1), .NUM_STAGES(3), .FILTER_CYCLES(0), .RST_VAL(1'b0)) dut_c (
        .CLK_Dst(clk), .RST_S(rst_n), .ASYNC_S(c_in), .SYNC_S(c_sync),
        .RISE_P(c_rise), .FALL_P(c_fall), .CHG_P(c_chg), .GLITCH_P(c_glitch));

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] sa, ra, fa, ga;
        logic [3:0] sb, rb, fb, gb;
    } exp_t;

    typedef struct packed {
        logic [3:0] in, sync, rise, fall, glitch;
    } vec_t;

    exp_t exp_q[$];
    logic c_q[$];
    logic c_prev;
    int   c_cnt = 0;

    // Reference state for dut_a (index 0, no filter) and dut_b (index 1, 3-cycle filter)
    logic [3:0] m_s0[2], m_s1[2], m_sync[2], m_rise[2], m_fall[2], m_gl[2];
    int         m_cnt[2][4];

    function automatic logic [3:0] rv(input int d);
        return (d == 0) ? 4'b1010 : 4'b0000;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_s0[d] = rv(d); m_s1[d] = rv(d); m_sync[d] = rv(d);
            m_rise[d] = '0; m_fall[d] = '0; m_gl[d] = '0;
            for (int ch = 0; ch < 4; ch++) m_cnt[d][ch] = 0;
        end
        c_q = '{1'b0, 1'b0, 1'b0};
        c_prev = 1'b0;
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int f;
            f = (d == 0) ? 0 : 3;
            for (int ch = 0; ch < 4; ch++) begin
                m_rise[d][ch] = 1'b0; m_fall[d][ch] = 1'b0; m_gl[d][ch] = 1'b0;
                if (m_s1[d][ch] == m_sync[d][ch]) begin
                    m_gl[d][ch] = (m_cnt[d][ch] != 0);
                    m_cnt[d][ch] = 0;
                end else if (m_cnt[d][ch] == f) begin
                    m_sync[d][ch] = m_s1[d][ch];
                    m_rise[d][ch] = m_s1[d][ch];
                    m_fall[d][ch] = ~m_s1[d][ch];
                    m_cnt[d][ch] = 0;
                end else begin
                    m_cnt[d][ch] = m_cnt[d][ch] + 1;
                end
            end
            m_s1[d] = m_s0[d];
            m_s0[d] = async_in;
        end
    endtask

    // One clock: drive inputs, predict, wait for the edge, compare just after it.
    task automatic step();
        exp_t e;
        logic c_exp;
        c_in = c_cnt[1];
        c_cnt++;
        if (rst_n) model_edge();
        e = '{m_sync[0], m_rise[0], m_fall[0], m_gl[0], m_sync[1], m_rise[1], m_fall[1], m_gl[1]};
        exp_q.push_back(e);
        if (rst_n) begin
            c_q.push_back(c_in);
            c_exp = c_q.pop_front();
        end else begin
            c_exp = 1'b0;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("a_sync", a_sync, e.sa);
        chk("a_rise", a_rise, e.ra);
        chk("a_fall", a_fall, e.fa);
        chk("a_chg", a_chg, e.ra | e.fa);
        chk("a_glitch", a_glitch, e.ga);
        chk("b_sync", b_sync, e.sb);
        chk("b_rise", b_rise, e.rb);
        chk("b_fall", b_fall, e.fb);
        chk("b_chg", b_chg, e.rb | e.fb);
        chk("b_glitch", b_glitch, e.gb);
        chk("c_sync", {3'b000, c_sync}, {3'b000, c_exp});
        chk("c_chg", {3'b000, c_chg}, {3'b000, c_exp ^ c_prev});
        chk("c_rise", {3'b000, c_rise}, {3'b000, c_exp & ~c_prev});
        chk("c_glitch", {3'b000, c_glitch}, 4'b0000);
        c_prev = c_exp;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        async_in = v;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[20];
        int   run[4];
        logic [3:0] cur;

        // Filter-3 channel 1: 3-cycle excursion rejected, then 4-cycle excursion accepted and dropped
        tbl[0]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        tbl[14] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        tbl[15] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        tbl[16] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        // Reset asserted mid-cycle: outputs must take reset values without waiting for a clock
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_a_sync", a_sync, 4'b1010);
        chk("rst_a_pulses", a_rise | a_fall | a_chg | a_glitch, 4'b0000);
        chk("rst_b_sync", b_sync, 4'b0000);
        chk("rst_b_pulses", b_rise | b_fall | b_chg | b_glitch, 4'b0000);
        chk("rst_c_sync", {3'b000, c_sync}, 4'b0000);
        step();
        step();
        #3 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("a_quiet_after_release", a_rise | a_fall | a_chg | a_glitch, 4'b0000);
        end
        hold(4'b0000, 12);

        // Clean rise on unfiltered ch0: visible on the 3rd edge counting the sampling edge
        async_in = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("clean_rise_sync", a_sync, (k >= 3) ? 4'b0001 : 4'b0000);
            chk("clean_rise_rise", a_rise, (k == 3) ? 4'b0001 : 4'b0000);
            chk("clean_rise_chg", a_chg, (k == 3) ? 4'b0001 : 4'b0000);
            chk("clean_rise_fall", a_fall, 4'b0000);
        end
        hold(4'b0001, 5);
        hold(4'b0000, 10);

        for (int r = 0; r < 20; r++) begin
            async_in = tbl[r].in;
            step();
            chk("tbl_b_sync", b_sync, tbl[r].sync);
            chk("tbl_b_rise", b_rise, tbl[r].rise);
            chk("tbl_b_fall", b_fall, tbl[r].fall);
            chk("tbl_b_chg", b_chg, tbl[r].rise | tbl[r].fall);
            chk("tbl_b_glitch", b_glitch, tbl[r].glitch);
        end

        // Independence: ch0 rises and ch2 falls on the same edge
        hold(4'b0100, 8);
        async_in = 4'b0001;
        step();
        step();
        step();
        chk("indep_rise", a_rise, 4'b0001);
        chk("indep_fall", a_fall, 4'b0100);
        chk("indep_sync", a_sync, 4'b0001);
        hold(4'b0001, 7);

        // Reset while ch3 of the filtered instance has a pending count of 2
        hold(4'b1001, 10);
        hold(4'b0001, 4);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_b_sync", b_sync, 4'b0000);
        chk("midrst_b_glitch", b_glitch, 4'b0000);
        chk("midrst_a_sync", a_sync, 4'b1010);
        step();
        step();
        #3 rst_n = 1'b1;
        async_in = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("post_rst_b_sync", b_sync, (k >= 6) ? 4'b0001 : 4'b0000);
            chk("post_rst_b_rise", b_rise, (k == 6) ? 4'b0001 : 4'b0000);
            chk("post_rst_b_glitch", b_glitch, 4'b0000);
        end

        // Random per-channel run lengths 1..6 exercise both rejection and acceptance
        cur = async_in;
        for (int ch = 0; ch < 4; ch++) run[ch] = 0;
        for (int k = 0; k < 300; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (run[ch] == 0) begin
                    cur[ch] = ~cur[ch];
                    run[ch] = $urandom_range(1, 6);
                end
                run[ch] = run[ch] - 1;
            end
            async_in = cur;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_bank_filt.md
Name: sync_bank_filt

Overview:
- Multi-channel, parametrised successor to the single-bit level synchronizer.
- Each channel passes through an N-stage flop chain into the destination clock domain, then an optional glitch/debounce filter.
- Per channel it outputs the synchronized level plus registered one-cycle rise, fall, change and glitch-rejected pulses.
- Sits at async inputs and CDC boundaries (status bits, flags, external pins) feeding control FSMs.

Parameters:
- NUM_CHANNELS, 4, number of independent single-bit channels (>=1).
- NUM_STAGES, 2, synchronizer flops per channel (>=2).
- FILTER_CYCLES, 0, extra consecutive stable samples required before the output follows (0 = no filtering).
- RST_VAL, {NUM_CHANNELS{1'b0}}, per-channel reset level of the sync chain and SYNC_S.

Ports:
- CLK_Dst, input, 1, destination clock; all flops on its rising edge.
- RST_S, input, 1, asynchronous active-low reset.
- ASYNC_S, input, NUM_CHANNELS, asynchronous inputs; no timing relation to CLK_Dst.
- SYNC_S, output, NUM_CHANNELS, synchronized and filtered levels (registered).
- RISE_P, output, NUM_CHANNELS, one-cycle pulse in the first cycle SYNC_S[i] reads 1 after reading 0.
- FALL_P, output, NUM_CHANNELS, one-cycle pulse in the first cycle SYNC_S[i] reads 0 after reading 1.
- CHG_P, output, NUM_CHANNELS, RISE_P | FALL_P (registered, not derived combinationally at the output).
- GLITCH_P, output, NUM_CHANNELS, one-cycle pulse when a pending change is abandoned by the filter.

Behaviour:
- Reset:
  - RST_S low asynchronously forces every chain stage[i] and SYNC_S[i] to RST_VAL[i].
  - Filter counters go to 0.
  - RISE_P, FALL_P, CHG_P and GLITCH_P go to 0.
  - Reset release generates no pulses.
- Chain:
  - stage0 <= ASYNC_S[i]; stage k <= stage k-1.
  - last = stage NUM_STAGES-1.
  - Channels are fully independent; no bus coherency is guaranteed. Multi-bit values must be gray-coded by the user.
- Filter, per channel; cnt is a counter of width clog2(FILTER_CYCLES+1), minimum 1 bit.
  - If last == SYNC_S: cnt <= 0. If cnt was non-zero, GLITCH_P <= 1 for one cycle.
  - If last != SYNC_S and cnt == FILTER_CYCLES: SYNC_S <= last, cnt <= 0.
  - If last != SYNC_S and cnt < FILTER_CYCLES: cnt <= cnt+1; SYNC_S holds.
  - With FILTER_CYCLES=0, SYNC_S follows last with 1 cycle delay and GLITCH_P is constant 0.
- Latency: an input change that stays stable appears on SYNC_S NUM_STAGES+1+FILTER_CYCLES rising edges after the first edge that samples it.
- Rejection: any excursion seen at last for <= FILTER_CYCLES consecutive cycles is rejected. SYNC_S is unchanged and GLITCH_P pulses on the edge where last returns.
- Pulses:
  - RISE_P, FALL_P and CHG_P are registered in the same edge that updates SYNC_S, so they coincide with the new SYNC_S value for exactly one cycle.
  - They are 0 in all other cycles.
- Back-to-back changes: with FILTER_CYCLES=0, an input toggling every cycle yields CHG_P high on consecutive cycles, each cycle tracking SYNC_S.
- Reset mid-filter: pending count is discarded; SYNC_S returns to RST_VAL; no GLITCH_P is issued.
- Simultaneous events on different channels are processed independently in the same cycle.

Test Plan:
- Reset level (NUM_CHANNELS=4, RST_VAL=4'b1010, ASYNC_S=4'b1010):
  - Stimulus: assert RST_S low mid-cycle, then release.
  - Required: SYNC_S=4'b1010 immediately on assert; all pulse outputs 0 throughout, including after release.
- Clean rise (NUM_STAGES=2, FILTER_CYCLES=0):
  - Stimulus: ASYNC_S[0] 0->1, held.
  - Required: SYNC_S[0]=1 on the 3rd rising edge after the sampling edge. RISE_P[0]=CHG_P[0]=1 for exactly that cycle; FALL_P=0.
- Glitch rejection (NUM_STAGES=2, FILTER_CYCLES=3):
  - Stimulus: ASYNC_S[1] high for 3 cycles.
  - Required: SYNC_S[1] stays 0, RISE_P[1] never asserts, GLITCH_P[1] pulses once.
  - Stimulus: same channel high for 4 cycles.
  - Required: SYNC_S[1] rises 6 edges after first sample; RISE_P[1] pulses once; then after the fall, SYNC_S[1] falls with FALL_P[1] pulse.
- Independence:
  - Stimulus: ch0 rises while ch2 falls in the same cycle.
  - Required: RISE_P=4'b0001 and FALL_P=4'b0100 in the same cycle; ch1/ch3 outputs unchanged.
- Reset mid-operation (FILTER_CYCLES=3):
  - Stimulus: assert RST_S while cnt=2 on ch3.
  - Required: SYNC_S[3]=RST_VAL[3] at once; no GLITCH_P. After release with stable input, full latency from scratch.
- Parameter sweep: NUM_STAGES=3, NUM_CHANNELS=1, FILTER_CYCLES=0.
  - Stimulus: input toggles every 2 cycles.
  - Required: SYNC_S reproduces the waveform delayed 4 edges; CHG_P pulses every 2 cycles.
